// File: rtl/limb_wb_interface.sv
// LIMB host bus to single-word Wishbone classic master bridge.
// Host strobes are synchronised into clk; one Wishbone cycle is run per transaction.
module limb_wb_interface (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  limb_d_in,
  output logic [7:0]  limb_d_out,
  output logic        limb_d_oe,
  input  logic        limb_clk,
  input  logic        limb_nrd,
  input  logic        limb_start,
  output logic        limb_nwait,
  output logic [35:0] wb_adr_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WB_WR, WB_RD, RDATA} state_t;

  logic       lclk_s1_q, lclk_s2_q, lclk_prev_q;
  logic       start_s1_q, start_s2_q;
  logic       nrd_s1_q, nrd_s2_q;
  logic [7:0] din_s1_q, din_s2_q;
  logic       limb_edge;

  state_t      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic [35:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        nrd_q, nrd_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic        nwait_q, nwait_d;
  logic        oe_q, oe_d;
  logic [7:0]  d_out_q, d_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lclk_s1_q   <= 1'b0;
      lclk_s2_q   <= 1'b0;
      lclk_prev_q <= 1'b0;
      start_s1_q  <= 1'b0;
      start_s2_q  <= 1'b0;
      nrd_s1_q    <= 1'b0;
      nrd_s2_q    <= 1'b0;
      din_s1_q    <= 8'h00;
      din_s2_q    <= 8'h00;
    end else begin
      lclk_s1_q   <= limb_clk;
      lclk_s2_q   <= lclk_s1_q;
      lclk_prev_q <= lclk_s2_q;
      start_s1_q  <= limb_start;
      start_s2_q  <= start_s1_q;
      nrd_s1_q    <= limb_nrd;
      nrd_s2_q    <= nrd_s1_q;
      din_s1_q    <= limb_d_in;
      din_s2_q    <= din_s1_q;
    end
  end

  assign limb_edge = lclk_s2_q & ~lclk_prev_q;

  // Address, write data and read data are shifted MSB first, one byte per host edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    nrd_d   = nrd_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    nwait_d = nwait_q;
    if (limb_edge && start_s2_q && (state_q != WB_WR) && (state_q != WB_RD)) begin
      adr_d[35:32] = din_s2_q[3:0];
      nrd_d        = nrd_s2_q;
      count_d      = 3'd1;
      state_d      = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (limb_edge) begin
            adr_d[31:0] = {adr_q[23:0], din_s2_q};
            if (count_q == 3'd4) begin
              count_d = 3'd0;
              if (nrd_q) begin
                state_d = WDATA;
              end else begin
                state_d = WB_RD;
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                nwait_d = 1'b0;
              end
            end else begin
              count_d = count_q + 3'd1;
            end
          end
        end
        WDATA: begin
          if (limb_edge) begin
            dat_d = {dat_q[23:0], din_s2_q};
            if (count_q == 3'd3) begin
              count_d = 3'd0;
              state_d = WB_WR;
              cyc_d   = 1'b1;
              we_d    = 1'b1;
              nwait_d = 1'b0;
            end else begin
              count_d = count_q + 3'd1;
            end
          end
        end
        WB_WR: begin
          if (wb_ack_i) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            nwait_d = 1'b1;
            state_d = IDLE;
          end
        end
        WB_RD: begin
          if (wb_ack_i) begin
            rdata_d = wb_dat_i;
            cyc_d   = 1'b0;
            nwait_d = 1'b1;
            count_d = 3'd0;
            state_d = RDATA;
          end
        end
        RDATA: begin
          if (limb_edge) begin
            rdata_d = {rdata_q[23:0], 8'h00};
            if (count_q == 3'd3) begin
              count_d = 3'd0;
              state_d = IDLE;
            end else begin
              count_d = count_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    oe_d    = (state_d == RDATA) && !nrd_s2_q;
    d_out_d = (state_d == RDATA) ? rdata_d[31:24] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      adr_q   <= 36'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      nrd_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      nwait_q <= 1'b1;
      oe_q    <= 1'b0;
      d_out_q <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      nrd_q   <= nrd_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      nwait_q <= nwait_d;
      oe_q    <= oe_d;
      d_out_q <= d_out_d;
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_sel_o   = 4'hF;
  assign limb_nwait = nwait_q;
  assign limb_d_oe  = oe_q;
  assign limb_d_out = d_out_q;

endmodule

// File: tb/tb_limb_wb_interface.sv
// Testbench for limb_wb_interface: a LIMB host driver, a Wishbone RAM slave with
// programmable wait states, and a transaction-level memory model for expected values.
module tb_limb_wb_interface;

  logic        clk;
  logic        rst;
  logic [7:0]  limbDIn;
  logic [7:0]  limbDOut;
  logic        limbDOe;
  logic        limbClk;
  logic        limbNrd;
  logic        limbStart;
  logic        limbNwait;
  logic [35:0] wbAdr;
  logic        wbWe;
  logic [3:0]  wbSel;
  logic        wbStb;
  logic        wbCyc;
  logic [31:0] wbDatO;
  logic [31:0] wbDatI;
  logic        wbAck;

  limb_wb_interface dut (
    .clk        (clk),
    .rst        (rst),
    .limb_d_in  (limbDIn),
    .limb_d_out (limbDOut),
    .limb_d_oe  (limbDOe),
    .limb_clk   (limbClk),
    .limb_nrd   (limbNrd),
    .limb_start (limbStart),
    .limb_nwait (limbNwait),
    .wb_adr_o   (wbAdr),
    .wb_we_o    (wbWe),
    .wb_sel_o   (wbSel),
    .wb_stb_o   (wbStb),
    .wb_cyc_o   (wbCyc),
    .wb_dat_o   (wbDatO),
    .wb_dat_i   (wbDatI),
    .wb_ack_i   (wbAck)
  );

  typedef struct {
    bit          isRead;
    logic [7:0]  b0;
    logic [31:0] adrLo;
    logic [31:0] wdata;
    int          waits;
    logic [35:0] expAdr;
    logic [31:0] expDat;
  } vec_t;

  typedef struct {
    logic [35:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          len;
    bit          stable;
    bit          nwaitLow;
  } wbRec_t;

  int          errCount = 0;
  int          checkCount = 0;
  int          slaveWaits = 0;
  int          nwaitLowCycles = 0;
  wbRec_t      wbQ[$];
  logic [31:0] slaveMem [logic [35:0]];
  logic [31:0] modelMem [logic [35:0]];

  // Free-running system clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents the RAM returns for locations that were never written.
  function automatic logic [31:0] defaultWord(input logic [35:0] a);
    return a[31:0] ^ 32'h5A5A5A5A;
  endfunction

  // Counts every cycle the bridge holds off the host, so a transaction can tell
  // whether limb_nwait dropped at some point.
  always @(negedge clk) begin
    if (!limbNwait) nwaitLowCycles++;
  end

  // Wishbone RAM slave: acks after slaveWaits wait states and logs each completed
  // cycle, with its length, whether adr/dat/we held still and whether nwait stayed low.
  bit          inCycle = 0;
  int          waitCnt = 0;
  wbRec_t      cur;
  always @(negedge clk) begin
    if (wbCyc && wbStb && !rst) begin
      if (!inCycle) begin
        inCycle      = 1;
        waitCnt      = 0;
        cur.adr      = wbAdr;
        cur.dat      = wbDatO;
        cur.we       = wbWe;
        cur.sel      = wbSel;
        cur.len      = 0;
        cur.stable   = 1;
        cur.nwaitLow = 1;
      end
      cur.len++;
      if (wbAdr !== cur.adr || wbDatO !== cur.dat || wbWe !== cur.we) cur.stable = 0;
      if (limbNwait) cur.nwaitLow = 0;
      if (waitCnt >= slaveWaits) begin
        wbAck = 1'b1;
        if (cur.we) begin
          slaveMem[cur.adr] = cur.dat;
        end else begin
          wbDatI  = slaveMem.exists(cur.adr) ? slaveMem[cur.adr] : defaultWord(cur.adr);
          cur.dat = wbDatI;
        end
        wbQ.push_back(cur);
        inCycle = 0;
      end else begin
        wbAck  = 1'b0;
        wbDatI = $urandom;
        waitCnt++;
      end
    end else begin
      wbAck   = 1'b0;
      wbDatI  = $urandom;
      inCycle = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One host strobe: 5 clk high, 5 clk low, edges offset from the system clock.
  task automatic limbByte(input logic [7:0] b, input logic st, input logic nrdVal);
    limbDIn   = b;
    limbStart = st;
    limbNrd   = nrdVal;
    #23 limbClk = 1'b1;
    #50 limbClk = 1'b0;
    #27;
  endtask

  task automatic sendHeader(input logic [7:0] b0, input logic [31:0] adrLo, input logic nrdVal);
    logic [31:0] sh;
    sh = adrLo;
    limbByte(b0, 1'b1, nrdVal);
    for (int i = 0; i < 4; i++) begin
      limbByte(sh[31:24], 1'b0, nrdVal);
      sh = sh << 8;
    end
  endtask

  task automatic waitNwaitHigh(output bit ok);
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (limbNwait) ok = 1;
    end
  endtask

  // Runs one full host transaction and checks both the Wishbone side and the host side.
  task automatic applyStimulus(input vec_t v);
    logic [31:0] sh;
    bit          ok;
    int          lowBefore;
    wbRec_t      rec;
    slaveWaits = v.waits;
    lowBefore  = nwaitLowCycles;
    sendHeader(v.b0, v.adrLo, !v.isRead);
    if (!v.isRead) begin
      sh = v.wdata;
      for (int i = 0; i < 4; i++) begin
        limbByte(sh[31:24], 1'b0, 1'b1);
        sh = sh << 8;
      end
      modelMem[{v.b0[3:0], v.adrLo}] = v.wdata;
    end
    waitNwaitHigh(ok);
    checkOutput("nwait_returns_high", 64'(ok), 64'd1);
    checkOutput("nwait_pulsed_low", 64'(nwaitLowCycles > lowBefore), 64'd1);
    checkOutput("wb_cycle_count", 64'(wbQ.size()), 64'd1);
    if (wbQ.size() > 0) begin
      rec = wbQ[0];
      checkOutput("wb_adr", 64'(rec.adr), 64'(v.expAdr));
      checkOutput("wb_we", 64'(rec.we), 64'(!v.isRead));
      checkOutput("wb_sel", 64'(rec.sel), 64'hF);
      checkOutput("wb_len", 64'(rec.len), 64'(v.waits + 1));
      checkOutput("wb_stable", 64'(rec.stable), 64'd1);
      checkOutput("nwait_low_in_cycle", 64'(rec.nwaitLow), 64'd1);
      if (!v.isRead) checkOutput("wb_dat", 64'(rec.dat), 64'(v.expDat));
    end
    if (v.isRead) begin
      sh = v.expDat;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput("rd_oe", 64'(limbDOe), 64'd1);
        checkOutput("rd_byte", 64'(limbDOut), 64'(sh[31:24]));
        limbByte(8'h00, 1'b0, 1'b0);
        sh = sh << 8;
      end
      @(negedge clk);
      checkOutput("rd_oe_after", 64'(limbDOe), 64'd0);
      limbNrd = 1'b1;
    end
    wbQ.delete();
    repeat (3) @(negedge clk);
  endtask

  vec_t table_[5];
  vec_t rv;
  bit   seen;
  bit   ok;

  // Main sequence: reset state, directed table, multi-cycle corner cases, random traffic.
  initial begin
    rst       = 1'b1;
    limbClk   = 1'b0;
    limbStart = 1'b0;
    limbNrd   = 1'b1;
    limbDIn   = 8'h00;
    wbAck     = 1'b0;
    wbDatI    = 32'h0;

    table_[0] = '{0, 8'h00, 32'h00000003, 32'hDEADBEEF, 0, 36'h000000003, 32'hDEADBEEF};
    table_[1] = '{1, 8'h00, 32'h00000003, 32'h00000000, 0, 36'h000000003, 32'hDEADBEEF};
    table_[2] = '{0, 8'hA5, 32'h00000040, 32'hCAFEF00D, 5, 36'h500000040, 32'hCAFEF00D};
    table_[3] = '{1, 8'h35, 32'h00000040, 32'h00000000, 2, 36'h500000040, 32'hCAFEF00D};
    table_[4] = '{1, 8'h02, 32'h00000100, 32'h00000000, 0, 36'h200000100, 32'h5A5A5B5A};

    #23;
    checkOutput("rst_cyc", 64'(wbCyc), 64'd0);
    checkOutput("rst_stb", 64'(wbStb), 64'd0);
    checkOutput("rst_we", 64'(wbWe), 64'd0);
    checkOutput("rst_adr", 64'(wbAdr), 64'd0);
    checkOutput("rst_dat", 64'(wbDatO), 64'd0);
    checkOutput("rst_sel", 64'(wbSel), 64'hF);
    checkOutput("rst_nwait", 64'(limbNwait), 64'd1);
    checkOutput("rst_oe", 64'(limbDOe), 64'd0);
    checkOutput("rst_dout", 64'(limbDOut), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus(table_[i]);

    // Strobes without start in IDLE must not begin anything.
    limbByte(8'h55, 1'b0, 1'b1);
    limbByte(8'h66, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("idle_ignore_wb", 64'(wbQ.size()), 64'd0);
    checkOutput("idle_ignore_nwait", 64'(limbNwait), 64'd1);

    // Abandoned address phase followed by a complete write to a new address.
    limbByte(8'h07, 1'b1, 1'b1);
    limbByte(8'h11, 1'b0, 1'b1);
    limbByte(8'h22, 1'b0, 1'b1);
    checkOutput("abort_no_wb", 64'(wbQ.size()), 64'd0);
    rv = '{0, 8'h0F, 32'h00000001, 32'h12345678, 0, 36'hF00000001, 32'h12345678};
    applyStimulus(rv);

    // Asynchronous reset while a write cycle is stalled by the slave.
    slaveWaits = 1000;
    sendHeader(8'h01, 32'h00000077, 1'b1);
    for (int i = 0; i < 4; i++) limbByte(8'h99, 1'b0, 1'b1);
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (wbCyc) seen = 1;
    end
    checkOutput("rst_mid_cyc_seen", 64'(seen), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_cyc", 64'(wbCyc), 64'd0);
    checkOutput("rst_mid_stb", 64'(wbStb), 64'd0);
    checkOutput("rst_mid_we", 64'(wbWe), 64'd0);
    checkOutput("rst_mid_nwait", 64'(limbNwait), 64'd1);
    checkOutput("rst_mid_oe", 64'(limbDOe), 64'd0);
    #17 rst = 1'b0;
    slaveWaits = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_no_wb", 64'(wbQ.size()), 64'd0);
    wbQ.delete();

    // Random traffic over a small address set so reads often hit earlier writes.
    for (int n = 0; n < 20; n++) begin
      logic [3:0] hi;
      logic [3:0] lo;
      int         pre;
      hi        = 4'($urandom_range(0, 15));
      lo        = 4'($urandom_range(0, 3));
      rv.isRead = bit'($urandom_range(0, 1));
      rv.b0     = {hi, lo};
      rv.adrLo  = 32'($urandom_range(0, 3));
      rv.wdata  = $urandom;
      rv.waits  = $urandom_range(0, 3);
      rv.expAdr = {lo, rv.adrLo};
      if (rv.isRead)
        rv.expDat = modelMem.exists(rv.expAdr) ? modelMem[rv.expAdr] : defaultWord(rv.expAdr);
      else
        rv.expDat = rv.wdata;
      if ($urandom_range(0, 2) == 0) begin
        pre = $urandom_range(1, 8);
        limbByte(8'($urandom), 1'b1, 1'b1);
        for (int k = 1; k < pre; k++) limbByte(8'($urandom), 1'b0, 1'b1);
      end
      applyStimulus(rv);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  // Guards against a hang anywhere in the sequence.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/limb_wb_interface.md
Name: limb_wb_interface

Overview:
- Bridges the byte-wide, host-clocked LIMB bus to a single-word Wishbone classic master (32-bit data, 36-bit word address).
- The host shifts in a 5-byte address, then either 4 write-data bytes or reads back 4 data bytes.
- The block runs a single Wishbone cycle per transaction and throttles the host with limb_nwait.
- The top level merges limb_d_in/limb_d_out/limb_d_oe into one inout bus.

Parameters:
- None.

Ports:
- clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- limb_d_in  in  8  LIMB data from host.
- limb_d_out  out  8  LIMB data to host.
- limb_d_oe  out  1  enables the limb_d_out drivers.
- limb_clk  in  1  host strobe; asynchronous to clk; data is taken on its rising edge.
- limb_nrd  in  1  0 = read transaction, 1 = write; held constant for the whole transaction.
- limb_start  in  1  high on the first byte of a transaction.
- limb_nwait  out  1  0 = bridge busy; the host must not raise limb_clk.
- wb_adr_o  out  36  word address.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  acknowledge.

Behaviour:
- Reset values: wb_cyc_o/wb_stb_o/wb_we_o = 0, wb_adr_o = 0, wb_dat_o = 0, wb_sel_o = 4'hF, limb_nwait = 1, limb_d_oe = 0, limb_d_out = 0, state IDLE.
- Synchronisation:
  - limb_clk, limb_start, limb_nrd and limb_d_in pass through a 2-flop synchroniser.
  - A rising edge is detected when the synchronised limb_clk is 1 and was 0 one clk earlier.
  - All LIMB fields are sampled at that detection cycle.
- Host timing requirements:
  - limb_clk high and low phases are each at least 4 clk periods.
  - Data, start and nrd are stable from setup through 4 clk periods after the limb_clk rise.
- States: IDLE, ADDR, WDATA, WB_WR, WB_RD, RDATA.
- Any edge with limb_start=1 in IDLE/ADDR/WDATA/RDATA aborts the current transaction and starts a new one:
  - Byte = address byte 0; adr[35:32] = byte[3:0]; byte[7:4] ignored.
  - nrd is latched.
  - limb_d_oe drops; state → ADDR with count 1.
- Edges with limb_start=0 in IDLE are ignored.
- ADDR: address bytes 1..4 follow, MSB first, filling adr[31:24], [23:16], [15:8], [7:0].
  - After byte 4, write transactions → WDATA.
  - After byte 4, read transactions → WB_RD (asserts cyc/stb, we=0, limb_nwait=0 on the cycle after detection).
- WDATA: 4 bytes, MSB first, fill wb_dat_o[31:24] .. [7:0].
  - After the 4th byte → WB_WR: cyc=stb=we=1, limb_nwait=0.
- WB_WR / WB_RD:
  - cyc/stb/we/adr/dat held stable until wb_ack_i is sampled high.
  - On the cycle after ack: cyc=stb=we=0, limb_nwait=1.
  - In WB_RD, wb_dat_i is latched on the ack cycle.
  - Zero or more wait-state cycles before ack are allowed; no timeout.
  - limb_clk edges and limb_start during WB_* are ignored (host protocol violation).
  - WB_WR → IDLE.
  - WB_RD → RDATA with index 0.
- RDATA:
  - limb_d_out = latched word byte[index], MSB first (index 0 = [31:24]).
  - limb_d_oe = 1 while in RDATA and synchronised limb_nrd = 0.
  - Each limb_clk rising edge (start=0) advances index; the host captures the byte on that edge.
  - After the 4th edge: limb_d_oe=0, state → IDLE.
- wb_sel_o is constant 4'hF; there are no partial-word accesses and no address auto-increment.
- limb_nwait goes low within 3 clk of the final byte's limb_clk rise.
  - The host must sample limb_nwait no earlier than 4 clk after that rise.
- Reset mid-operation forces all reset values immediately, including dropping cyc/stb.

Test Plan:
- Reset: assert rst asynchronously mid-WB_WR → cyc/stb/we = 0, limb_nwait = 1, limb_d_oe = 0 without waiting for clk.
- Write: start byte 0x00, then 0x00 0x00 0x00 0x03, then 0xDE 0xAD 0xBE 0xEF (nrd=1), zero-wait RAM → one cycle with wb_adr_o=36'h3, wb_dat_o=32'hDEADBEEF, we=1, sel=F; limb_nwait pulses low then returns to 1.
- Read-back: nrd=0, address 0x0_0000_0003, 4 data edges → limb_d_out sequence 0xDE, 0xAD, 0xBE, 0xEF with limb_d_oe=1 throughout; oe=0 afterward; WB cycle has we=0.
- Wait states: slave delays ack by 5 clk → stb/cyc held for 6 cycles with stable adr/dat; limb_nwait low for the whole cycle.
- Abort: start + 2 address bytes, then new start sequence to address 0xF_0000_0001 writing 0x12345678 → single WB write at 36'hF00000001 with 0x12345678.
- High nibble: address byte 0 = 0xA5 → wb_adr_o[35:32] = 4'h5.
